// File: rtl/cpu_bus_guard_pkg.sv
// Shared constants and request type for the CPU bus guard.
// Build option CPU_BUS_GUARD_LOG_EN enables the abort log in cpu_bus_guard.
package cpu_bus_guard_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int          DEFAULT_TIMEOUT     = 255;
  localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'h0;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Wait-cycle counter: cleared on request accept, counts while enabled, flags expiry at LIMIT.
// Latency: expired is a direct decode of the count; it holds rather than wraps once reached.
module bus_timeout_counter
  import cpu_bus_guard_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(LIMIT));

endmodule

// File: rtl/cpu_bus_guard.sv
// Registers a CPU request toward the MMIO mux and answers with TIMEOUT_RDATA if the mux stays silent.
// Latency 1 cycle each way; abort answers TIMEOUT_CYCLES+1 cycles after dev_valid. Log via CPU_BUS_GUARD_LOG_EN.
module cpu_bus_guard
  import cpu_bus_guard_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter logic [31:0] TIMEOUT_RDATA  = ILLEGAL_INSTRUCTION
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        dev_valid,
  output logic        dev_instr,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_wstrb,
  input  logic        dev_ready,
  input  logic [31:0] dev_rdata,
  output logic        timeout,
  input  logic        err_clear,
  output logic        err_valid,
  output logic [31:0] err_addr,
  output logic [7:0]  err_count
);

  logic [1:0] state;
  bus_req_t   req;
  logic       expired;
  logic       abort_now;

  assign dev_valid = (state == ST_WAIT);
  assign cpu_ready = (state == ST_RESP);
  assign dev_instr = req.instr;
  assign dev_addr  = req.addr;
  assign dev_wdata = req.wdata;
  assign dev_wstrb = req.wstrb;

  // A device answer in the expiry cycle still wins over the abort.
  assign abort_now = (state == ST_WAIT) && !dev_ready && expired;

  bus_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   ((state == ST_IDLE) && cpu_valid),
    .enable  (state == ST_WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      req       <= '0;
      cpu_rdata <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= abort_now;
      case (state)
        ST_IDLE: begin
          if (cpu_valid) begin
            req   <= '{instr: cpu_instr, addr: cpu_addr, wdata: cpu_wdata, wstrb: cpu_wstrb};
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dev_ready) begin
            cpu_rdata <= dev_rdata;
            state     <= ST_RESP;
          end else if (expired) begin
            cpu_rdata <= TIMEOUT_RDATA;
            state     <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CPU_BUS_GUARD_LOG_EN
  // An abort coinciding with err_clear restarts the log with that abort.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else if (abort_now) begin
      err_count <= err_clear ? 8'd1 : sat_inc8(err_count);
      if (err_clear || !err_valid) begin
        err_valid <= 1'b1;
        err_addr  <= req.addr;
      end
    end else if (err_clear) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end
  end
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign err_valid        = 1'b0;
  assign err_addr         = '0;
  assign err_count        = '0;
`endif

endmodule

// File: tb/tb_cpu_bus_guard.sv
// Scoreboard bench for cpu_bus_guard: stimulus pushes expected responses, a monitor checks them.
module tb_cpu_bus_guard;

  localparam int T = 8;
`ifdef CPU_BUS_GUARD_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_instr = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        dev_ready = 1'b0;
  logic [31:0] dev_rdata = '0;
  logic        err_clear = 1'b0;
  logic        cpu_ready, dev_valid, dev_instr, timeout, err_valid;
  logic [31:0] cpu_rdata, dev_addr, dev_wdata, err_addr;
  logic [3:0]  dev_wstrb;
  logic [7:0]  err_count;

  cpu_bus_guard #(.TIMEOUT_CYCLES(T), .TIMEOUT_RDATA(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dev_valid(dev_valid), .dev_instr(dev_instr), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_wstrb(dev_wstrb), .dev_ready(dev_ready), .dev_rdata(dev_rdata), .timeout(timeout),
    .err_clear(err_clear), .err_valid(err_valid), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        to;
    int          lat;
    logic        ev;
    logic [31:0] ea;
    logic [7:0]  ec;
  } exp_t;

  exp_t q[$];

  // Reference abort log
  logic        m_ev = 1'b0;
  logic [31:0] m_ea = '0;
  logic [7:0]  m_ec = '0;

  task automatic model_clear();
    m_ev = 1'b0; m_ea = '0; m_ec = '0;
  endtask

  // d = WAIT cycle (1-based) in which the device answers, 0 = never.
  // late = extra dev_ready pulse in a later cycle, 0 = none.
  task automatic run_txn(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int d, input int late,
                         input logic [31:0] rd, input bit clr);
    exp_t e;
    bit   answered;
    bit   seen;
    answered = (d >= 1) && (d <= T + 1);
    e.instr = instr; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
    e.rdata = answered ? rd : 32'h0;
    e.to    = !answered;
    e.lat   = answered ? d : T + 1;
    if (LOG) begin
      if (!answered && clr) begin
        m_ec = 8'd1; m_ev = 1'b1; m_ea = addr;
      end else if (!answered) begin
        if (m_ec != 8'hff) m_ec = m_ec + 8'd1;
        if (!m_ev) begin m_ev = 1'b1; m_ea = addr; end
      end else if (clr) begin
        model_clear();
      end
    end
    e.ev = m_ev; e.ea = m_ea; e.ec = m_ec;
    q.push_back(e);

    @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = dev_valid;
    end
    if (!seen) begin
      chk("dev_valid_rise", {31'b0, dev_valid}, 32'd1);
      cpu_valid = 1'b0;
      void'(q.pop_back());
      return;
    end
    for (int w = 1; w <= T + 4; w++) begin
      if (w > 1) @(negedge clk);
      if (cpu_ready) cpu_valid = 1'b0;
      dev_ready = (w == d) || (w == late);
      dev_rdata = (w == d) ? rd : $urandom;
      err_clear = clr && (w == T + 1);
    end
    @(negedge clk);
    dev_ready = 1'b0; err_clear = 1'b0; cpu_valid = 1'b0;
  endtask

  task automatic clear_log_alone();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    model_clear();
    chk("clear_err_valid", {31'b0, err_valid}, 32'd0);
    chk("clear_err_addr", err_addr, 32'd0);
    chk("clear_err_count", {24'b0, err_count}, 32'd0);
  endtask

  // Monitor: request fields at dev_valid rise, stability while valid, response at cpu_ready.
  logic pdv = 1'b0;
  int   rise = 0;
  exp_t snap;
  exp_t got;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dev_valid && !pdv) begin
        rise = cyc;
        if (q.size() == 0) begin
          chk("dev_valid_spurious", {31'b0, dev_valid}, 32'd0);
        end else begin
          snap = q[0];
          chk("dev_instr", {31'b0, dev_instr}, {31'b0, snap.instr});
          chk("dev_addr", dev_addr, snap.addr);
          chk("dev_wdata", dev_wdata, snap.wdata);
          chk("dev_wstrb", {28'b0, dev_wstrb}, {28'b0, snap.wstrb});
        end
      end else if (dev_valid && q.size() > 0) begin
        chk("dev_addr_stable", dev_addr, snap.addr);
        chk("dev_wdata_stable", dev_wdata, snap.wdata);
      end
      if (cpu_ready) begin
        if (q.size() == 0) begin
          chk("cpu_ready_spurious", {31'b0, cpu_ready}, 32'd0);
        end else begin
          got = q.pop_front();
          chk("cpu_rdata", cpu_rdata, got.rdata);
          chk("timeout", {31'b0, timeout}, {31'b0, got.to});
          chk("latency", 32'(cyc - rise), 32'(got.lat));
          chk("err_valid", {31'b0, err_valid}, {31'b0, got.ev});
          chk("err_addr", err_addr, got.ea);
          chk("err_count", {24'b0, err_count}, {24'b0, got.ec});
        end
      end else if (timeout) begin
        chk("timeout_without_ready", {31'b0, timeout}, 32'd0);
      end
      pdv = dev_valid;
    end
  end

  initial begin
    exp_t e;
    logic [31:0] a;
    bit          seen;

    repeat (3) @(negedge clk);
    chk("rst_dev_valid", {31'b0, dev_valid}, 32'd0);
    chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dev_addr", dev_addr, 32'd0);
    chk("rst_dev_wdata", dev_wdata, 32'd0);
    chk("rst_dev_wstrb", {28'b0, dev_wstrb}, 32'd0);
    chk("rst_err_valid", {31'b0, err_valid}, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    reset_n = 1'b1;

    run_txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3, 0, 32'h1234_5678, 1'b0);
    run_txn(1'b0, 32'hc300_0000, 32'hdead_beef, 4'hf, 1, 0, 32'h0, 1'b0);
    run_txn(1'b1, 32'h0400_0040, 32'h0, 4'h0, 0, 0, 32'h5555_aaaa, 1'b0);
    run_txn(1'b0, 32'h0400_0080, 32'h0, 4'h0, T, T + 2, 32'h0bad_f00d, 1'b0);
    run_txn(1'b0, 32'h0400_00c0, 32'h0, 4'h0, T + 1, 0, 32'hcafe_0001, 1'b0);
    run_txn(1'b0, 32'hc300_0004, 32'h1111_2222, 4'h3, T + 2, 0, 32'h7777_0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 11), ($urandom_range(0, 1) == 1) ? $urandom_range(11, 12) : 0,
              $urandom, 1'b0);
    end

    clear_log_alone();
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      run_txn(1'b0, a, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0);
    end
    run_txn(1'b0, 32'hc300_0100, 32'h0, 4'h0, 0, 0, 32'h0, 1'b1);
    clear_log_alone();

    // Reset in the middle of an access
    e = '{instr: 1'b0, addr: 32'h0000_2000, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h0,
          to: 1'b0, lat: 0, ev: 1'b0, ea: 32'h0, ec: 8'h0};
    q.push_back(e);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h0000_2000; cpu_wdata = '0; cpu_wstrb = '0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = dev_valid;
    end
    chk("rstmid_dev_valid_rise", {31'b0, seen}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    cpu_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_dev_valid", {31'b0, dev_valid}, 32'd0);
    chk("rstmid_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    void'(q.pop_front());
    model_clear();
    @(negedge clk);
    chk("rstmid_cpu_ready_after", {31'b0, cpu_ready}, 32'd0);
    reset_n = 1'b1;
    run_txn(1'b0, 32'h0000_3000, 32'h0, 4'h0, 2, 0, 32'h600d_0001, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
